// File: rtl/cd1_weight_updater_if.sv
// Sample, weight and status bundle between the CD-1 weight updater and the RBM layer it trains.
interface cd1_weight_updater_if #(
    parameter int weight_bitlength = 12,
    parameter int in_dim           = 6,
    parameter int out_dim          = 5
);
    logic                                        StartI;
    logic [in_dim-1:0]                           V0I;
    logic [out_dim-1:0]                          H0I;
    logic [in_dim-1:0]                           V1I;
    logic [out_dim-1:0]                          H1I;
    logic [in_dim*out_dim*weight_bitlength-1:0]  WeightI;
    logic [out_dim*weight_bitlength-1:0]         BiasI;
    logic [in_dim*out_dim*weight_bitlength-1:0]  WeightO;
    logic [out_dim*weight_bitlength-1:0]         BiasO;
    logic                                        BusyO;
    logic                                        DoneO;

    modport master (
        output StartI, V0I, H0I, V1I, H1I, WeightI, BiasI,
        input  WeightO, BiasO, BusyO, DoneO
    );

    modport slave (
        input  StartI, V0I, H0I, V1I, H1I, WeightI, BiasI,
        output WeightO, BiasO, BusyO, DoneO
    );
endinterface

// File: rtl/cd1_weight_updater.sv
// CD-1 learning stage: snapshots one Gibbs step, then walks the weight matrix and hidden
// bias one element per clock, adding a saturated +/-weight_step per unit of delta.
module cd1_weight_updater #(
    parameter int weight_bitlength = 12,
    parameter int in_dim           = 6,
    parameter int out_dim          = 5,
    parameter int weight_step      = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    cd1_weight_updater_if.slave  bus
);
    localparam int WB = weight_bitlength;
    localparam int SW = WB + 2;
    localparam int N  = in_dim * out_dim;
    localparam int IW = (in_dim  > 1) ? $clog2(in_dim)  : 1;
    localparam int JW = (out_dim > 1) ? $clog2(out_dim) : 1;
    localparam int KW = (N       > 1) ? $clog2(N)       : 1;

    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (WB - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (WB - 1)));
    localparam logic signed [SW-1:0] STEP = SW'(weight_step);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_UPD_W = 3'd2;
    localparam logic [2:0] S_UPD_B = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [IW-1:0]           r_i;
    logic [JW-1:0]           r_j;
    logic [KW-1:0]           r_k;
    logic [in_dim-1:0]       r_v0;
    logic [in_dim-1:0]       r_v1;
    logic [out_dim-1:0]      r_h0;
    logic [out_dim-1:0]      r_h1;
    logic signed [WB-1:0]    r_w [N];
    logic signed [WB-1:0]    r_b [out_dim];
    logic                    r_busy;
    logic                    r_done;

    logic                    w_pos_w;
    logic                    w_neg_w;
    logic signed [SW-1:0]    w_wsum;
    logic signed [SW-1:0]    w_bsum;

    function automatic logic signed [WB-1:0] sat(input logic signed [SW-1:0] x);
        if (x > MAXV) return MAXV[WB-1:0];
        if (x < MINV) return MINV[WB-1:0];
        return x[WB-1:0];
    endfunction

    // Opposing phase terms cancel, so delta is always -1, 0 or +1.
    function automatic logic signed [SW-1:0] step_of(input logic pos, input logic neg);
        if (pos && !neg) return STEP;
        if (neg && !pos) return -STEP;
        return '0;
    endfunction

    assign w_pos_w = r_v0[r_i] & r_h0[r_j];
    assign w_neg_w = r_v1[r_i] & r_h1[r_j];
    assign w_wsum  = SW'(r_w[r_k]) + step_of(w_pos_w, w_neg_w);
    assign w_bsum  = SW'(r_b[r_j]) + step_of(r_h0[r_j], r_h1[r_j]);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_v0    <= '0;
            r_v1    <= '0;
            r_h0    <= '0;
            r_h1    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < N; k++) r_w[k] <= '0;
            for (int j = 0; j < out_dim; j++) r_b[j] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.StartI) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_v0    <= bus.V0I;
                    r_h0    <= bus.H0I;
                    r_v1    <= bus.V1I;
                    r_h1    <= bus.H1I;
                    for (int k = 0; k < N; k++) r_w[k] <= bus.WeightI[k*WB +: WB];
                    for (int j = 0; j < out_dim; j++) r_b[j] <= bus.BiasI[j*WB +: WB];
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= S_UPD_W;
                end
                S_UPD_W: begin
                    r_w[r_k] <= sat(w_wsum);
                    r_k      <= r_k + KW'(1);
                    if (r_j == JW'(out_dim - 1)) begin
                        r_j <= '0;
                        if (r_i == IW'(in_dim - 1)) begin
                            r_i     <= '0;
                            r_k     <= '0;
                            r_state <= S_UPD_B;
                        end else begin
                            r_i <= r_i + IW'(1);
                        end
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                S_UPD_B: begin
                    r_b[r_j] <= sat(w_bsum);
                    if (r_j == JW'(out_dim - 1)) begin
                        r_j     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                S_DONE: begin
                    // Two edges here: raise DoneO, then drop it and return idle without honouring StartI.
                    if (!r_done) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_wout
        assign bus.WeightO[k*WB +: WB] = r_w[k];
    end

    for (genvar j = 0; j < out_dim; j++) begin : g_bout
        assign bus.BiasO[j*WB +: WB] = r_b[j];
    end

    assign bus.BusyO = r_busy;
    assign bus.DoneO = r_done;
endmodule
